// File: rtl/sysid_reader_if.sv
// Avalon-MM read-only master/slave bundle used to reach the sysid control_slave.
interface sysid_reader_if;
  logic        avm_address;
  logic        avm_read;
  logic [31:0] avm_readdata;
  logic        avm_waitrequest;

  modport master (
    output avm_address,
    output avm_read,
    input  avm_readdata,
    input  avm_waitrequest
  );

  modport slave (
    input  avm_address,
    input  avm_read,
    output avm_readdata,
    output avm_waitrequest
  );
endinterface

// File: rtl/sysid_reader.sv
// Reads the sysid ID (address 0) and timestamp (address 1) words and compares
// them against the values the build expects. Every output is registered.
module sysid_reader #(
  parameter logic [31:0] EXPECTED_ID        = 32'd0,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1369035637,
  parameter int unsigned TIMEOUT_CYCLES     = 255
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  sysid_reader_if.master        avm,
  output logic                  busy,
  output logic                  done,
  output logic [31:0]           id_value,
  output logic [31:0]           timestamp_value,
  output logic                  match,
  output logic                  timeout_err
);

  typedef enum logic [1:0] {IDLE, RD_ID, RD_TS, DONE} state_t;

  localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT_CYCLES);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] id_q, id_d;
  logic [31:0] ts_q, ts_d;
  logic        match_q, match_d;
  logic        tmo_q, tmo_d;
  logic        read_q, read_d;
  logic        addr_q, addr_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  // Next-state, capture and flag logic; bus/status outputs are decoded from
  // the next state so they can be registered alongside it.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    id_d    = id_q;
    ts_d    = ts_q;
    match_d = match_q;
    tmo_d   = tmo_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RD_ID;
          cnt_d   = '0;
          match_d = 1'b0;
          tmo_d   = 1'b0;
        end
      end

      RD_ID: begin
        if (!avm.avm_waitrequest) begin
          id_d    = avm.avm_readdata;
          cnt_d   = '0;
          state_d = RD_TS;
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_q + 8'd1 == TMO_LIMIT) begin
            tmo_d   = 1'b1;
            match_d = 1'b0;
            state_d = DONE;
          end
        end
      end

      RD_TS: begin
        if (!avm.avm_waitrequest) begin
          ts_d    = avm.avm_readdata;
          cnt_d   = '0;
          match_d = (id_q == EXPECTED_ID) &&
                    (avm.avm_readdata == EXPECTED_TIMESTAMP) && !tmo_q;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_q + 8'd1 == TMO_LIMIT) begin
            tmo_d   = 1'b1;
            match_d = 1'b0;
            state_d = DONE;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    read_d = (state_d == RD_ID) || (state_d == RD_TS);
    addr_d = (state_d == RD_TS);
    busy_d = read_d;
    done_d = (state_d == DONE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      id_q    <= '0;
      ts_q    <= '0;
      match_q <= 1'b0;
      tmo_q   <= 1'b0;
      read_q  <= 1'b0;
      addr_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      id_q    <= id_d;
      ts_q    <= ts_d;
      match_q <= match_d;
      tmo_q   <= tmo_d;
      read_q  <= read_d;
      addr_q  <= addr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign avm.avm_read    = read_q;
  assign avm.avm_address = addr_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign id_value        = id_q;
  assign timestamp_value = ts_q;
  assign match           = match_q;
  assign timeout_err     = tmo_q;

endmodule

// File: tb/tb_sysid_reader.sv
// Scoreboard bench for sysid_reader: a stall-programmable sysid slave model,
// a transaction-level predictor and a done-driven monitor.
module tb_sysid_reader;
  localparam int unsigned T      = 4;
  localparam logic [31:0] EXP_ID = 32'd0;
  localparam logic [31:0] EXP_TS = 32'd1369035637;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        busy, done, match, timeout_err;
  logic [31:0] id_value, timestamp_value;

  sysid_reader_if bus();

  sysid_reader #(.TIMEOUT_CYCLES(T)) dut (
    .clock           (clock),
    .reset           (reset),
    .start           (start),
    .avm             (bus.master),
    .busy            (busy),
    .done            (done),
    .id_value        (id_value),
    .timestamp_value (timestamp_value),
    .match           (match),
    .timeout_err     (timeout_err)
  );

  always #5 clock = ~clock;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned cyc   = 0;

  typedef struct {
    int unsigned done_cyc;
    logic [31:0] id;
    logic [31:0] ts;
    logic        m;
    logic        t;
  } exp_t;

  exp_t sb[$];

  // Model of the values the DUT should be holding.
  logic [31:0] mdl_id = '0;
  logic [31:0] mdl_ts = '0;
  logic        mdl_m  = 1'b0;
  logic        mdl_t  = 1'b0;

  // Slave behaviour for the current check: stall cycles and data per address.
  int unsigned plan_w[2];
  logic [31:0] plan_d[2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%08h), expected %0d (0x%08h) at cycle %0d",
               name, act, act, req, req, cyc);
    end
  endtask

  // Transaction-level outcome of a check accepted in cycle n.
  task automatic predict(input int unsigned n);
    exp_t e;
    int unsigned w0 = plan_w[0];
    int unsigned w1 = plan_w[1];
    if (w0 >= T) begin
      e.done_cyc = n + T + 1;
      e.t = 1'b1;
    end else begin
      mdl_id = plan_d[0];
      if (w1 >= T) begin
        e.done_cyc = n + 2 + w0 + T;
        e.t = 1'b1;
      end else begin
        mdl_ts = plan_d[1];
        e.done_cyc = n + 3 + w0 + w1;
        e.t = 1'b0;
      end
    end
    e.m  = !e.t && (mdl_id == EXP_ID) && (mdl_ts == EXP_TS);
    e.id = mdl_id;
    e.ts = mdl_ts;
    mdl_m = e.m;
    mdl_t = e.t;
    sb.push_back(e);
  endtask

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  // Sysid slave: stalls each new read for the planned number of cycles.
  initial begin
    int unsigned remaining = 0;
    logic fresh = 1'b1;
    logic prev_stall = 1'b0;
    logic prev_addr = 1'b0;
    bus.avm_waitrequest = 1'b0;
    bus.avm_readdata    = '0;
    forever begin
      @(posedge clock);
      #1;
      if (prev_stall && bus.avm_read)
        check("addr_stable", 32'(bus.avm_address), 32'(prev_addr));
      if (bus.avm_read) begin
        if (fresh) begin
          remaining = plan_w[bus.avm_address];
          fresh = 1'b0;
        end
        if (remaining > 0) begin
          bus.avm_waitrequest = 1'b1;
          bus.avm_readdata    = $urandom;
          remaining--;
        end else begin
          bus.avm_waitrequest = 1'b0;
          bus.avm_readdata    = plan_d[bus.avm_address];
          fresh = 1'b1;
        end
      end else begin
        bus.avm_waitrequest = 1'b0;
        bus.avm_readdata    = $urandom;
        fresh = 1'b1;
      end
      prev_stall = bus.avm_read && bus.avm_waitrequest;
      prev_addr  = bus.avm_address;
    end
  end

  // Monitor: every done pulse is matched against the oldest prediction.
  initial forever begin
    exp_t e;
    @(negedge clock);
    if (!reset && done) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: got done=1, expected no completion at cycle %0d", cyc);
      end else begin
        e = sb.pop_front();
        check("done_cycle", cyc, e.done_cyc);
        check("id_value", id_value, e.id);
        check("timestamp_value", timestamp_value, e.ts);
        check("match", 32'(match), 32'(e.m));
        check("timeout_err", 32'(timeout_err), 32'(e.t));
        check("busy_at_done", 32'(busy), 32'd0);
        check("read_at_done", 32'(bus.avm_read), 32'd0);
      end
    end
  end

  task automatic wait_drain();
    for (int i = 0; i < 300 && sb.size() != 0; i++) @(negedge clock);
    check("drain", 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 50; i++) begin
      if (!busy && !done) break;
      @(negedge clock);
    end
    check("idle_reached", 32'(busy || done), 32'd0);
  endtask

  task automatic set_plan(input int unsigned w0, input int unsigned w1,
                          input logic [31:0] d0, input logic [31:0] d1);
    plan_w[0] = w0;
    plan_w[1] = w1;
    plan_d[0] = d0;
    plan_d[1] = d1;
  endtask

  task automatic check_held();
    check("held_id", id_value, mdl_id);
    check("held_ts", timestamp_value, mdl_ts);
    check("held_match", 32'(match), 32'(mdl_m));
    check("held_timeout", 32'(timeout_err), 32'(mdl_t));
  endtask

  task automatic run_check(input int unsigned w0, input int unsigned w1,
                           input logic [31:0] d0, input logic [31:0] d1);
    wait_drain();
    @(negedge clock);
    wait_idle();
    repeat ($urandom_range(0, 2)) @(negedge clock);
    check_held();
    set_plan(w0, w1, d0, d1);
    start = 1'b1;
    predict(cyc);
    @(posedge clock);
    #1 start = 1'b0;
  endtask

  task automatic check_reset_state();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_match", 32'(match), 32'd0);
    check("rst_timeout", 32'(timeout_err), 32'd0);
    check("rst_id", id_value, 32'd0);
    check("rst_ts", timestamp_value, 32'd0);
    check("rst_read", 32'(bus.avm_read), 32'd0);
    check("rst_addr", 32'(bus.avm_address), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned idle_at;
    logic [31:0] d0, d1;
    set_plan(0, 0, EXP_ID, EXP_TS);
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check_reset_state();

    // Directed: nominal, wrong timestamp, stalls, timeouts in each read.
    run_check(0, 0, EXP_ID, EXP_TS);
    run_check(0, 0, EXP_ID, EXP_TS - 32'd1);
    run_check(2, 2, EXP_ID, EXP_TS);
    run_check(9, 0, 32'h1234_5678, EXP_TS);
    run_check(0, 0, EXP_ID, EXP_TS);
    run_check(1, 9, 32'h0000_00AA, 32'h0BAD_F00D);
    run_check(3, 3, EXP_ID, EXP_TS);

    // Start held high: accepted only when idle, no queuing.
    wait_drain();
    @(negedge clock);
    wait_idle();
    set_plan(0, 0, EXP_ID, EXP_TS);
    idle_at = 0;
    start = 1'b1;
    repeat (8) begin
      if (cyc >= idle_at) begin
        predict(cyc);
        idle_at = cyc + 4;
      end
      @(negedge clock);
    end
    start = 1'b0;

    // Reset during the timestamp read discards the check.
    wait_drain();
    @(negedge clock);
    wait_idle();
    set_plan(0, 3, 32'h5555_5555, EXP_TS);
    start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("pre_reset_in_rd_ts", 32'({busy, bus.avm_address}), 32'd3);
    reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check_reset_state();
    mdl_id = '0;
    mdl_ts = '0;
    mdl_m  = 1'b0;
    mdl_t  = 1'b0;
    run_check(0, 0, EXP_ID, EXP_TS);

    // Randomized checks.
    for (int k = 0; k < 30; k++) begin
      d0 = ($urandom_range(0, 3) == 0) ? 32'($urandom) : EXP_ID;
      d1 = ($urandom_range(0, 3) == 0) ? 32'($urandom) : EXP_TS;
      run_check($urandom_range(0, 5), $urandom_range(0, 5), d0, d1);
    end

    wait_drain();
    repeat (3) @(negedge clock);
    check_held();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
